// File: rtl/iram_arbiter_pkg.sv
// iram_arbiter_pkg: shared state/owner encodings and default widths for the IRAM arbiter.
package iram_arbiter_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 128;
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0 = 2'b01;
  localparam logic [1:0] OWNER_M1 = 2'b10;
endpackage

// File: rtl/iram_arbiter_if.sv
// iram_arbiter_if: two burst masters, the SRAM port and status bundled for the IRAM arbiter.
interface iram_arbiter_if
  import iram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W/8-1:0] m0_wstrb;
  logic [7:0] m0_len;
  logic m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W/8-1:0] m1_wstrb;
  logic [7:0] m1_len;
  logic [DATA_W-1:0] rdata;
  logic ram_cen;
  logic [DATA_W/8-1:0] ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic [1:0] owner;
  modport slave (
    input m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb, m0_len,
    input m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_len, ram_dout,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output ram_cen, ram_wen, ram_addr, ram_din, owner
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb, m0_len,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_len, ram_dout,
    input m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input ram_cen, ram_wen, ram_addr, ram_din, owner
  );
endinterface

// File: rtl/iram_arbiter_rr_pick.sv
// iram_rr_pick: two-way round-robin picker; on a tie the master not served last wins.
module iram_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  assign valid = |req;
  assign winner = &req ? ~last : req[1];
endmodule

// File: rtl/iram_arbiter.sv
// iram_arbiter: burst-granular round-robin arbiter sharing one single-port SRAM between two masters.
module iram_arbiter
  import iram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic pll_core_cpuclk,
  input logic pad_cpu_rst_b,
  iram_arbiter_if.slave bus
);
  state_t state;
  logic [7:0] beat_rem;
  logic [1:0] owner_q;
  logic last, rvalid0, rvalid1, valid, winner;
  logic gnt0, gnt1, gnt, we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  iram_rr_pick u_pick (
    .req({bus.m1_req, bus.m0_req}),
    .last(last),
    .valid(valid),
    .winner(winner)
  );
  // Grants are gated by reset so nothing reaches the SRAM while reset is held.
  always_comb begin
    gnt0 = pad_cpu_rst_b && state == OWN0 && bus.m0_req;
    gnt1 = pad_cpu_rst_b && state == OWN1 && bus.m1_req;
    gnt = gnt0 | gnt1;
    we = gnt1 ? bus.m1_we : bus.m0_we;
    addr = gnt1 ? bus.m1_addr : gnt0 ? bus.m0_addr : '0;
    wdata = gnt1 ? bus.m1_wdata : gnt0 ? bus.m0_wdata : '0;
    wstrb = gnt1 ? bus.m1_wstrb : bus.m0_wstrb;
  end
  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;
  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.owner = owner_q;
  assign bus.rdata = bus.ram_dout;
  assign bus.ram_cen = ~gnt;
  assign bus.ram_wen = gnt && we ? ~wstrb : '1;
  assign bus.ram_addr = addr;
  assign bus.ram_din = wdata;
  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      state <= IDLE;
      beat_rem <= 8'd0;
      last <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      owner_q <= OWNER_IDLE;
    end else begin
      rvalid0 <= gnt0 && !bus.m0_we;
      rvalid1 <= gnt1 && !bus.m1_we;
      if (state == IDLE) begin
        if (valid) begin
          state <= winner ? OWN1 : OWN0;
          owner_q <= winner ? OWNER_M1 : OWNER_M0;
          beat_rem <= winner ? bus.m1_len : bus.m0_len;
        end
      end else if (gnt) begin
        if (beat_rem == 8'd0) begin
          state <= IDLE;
          owner_q <= OWNER_IDLE;
          last <= gnt1;
        end else begin
          beat_rem <= beat_rem - 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_iram_arbiter.sv
// tb_iram_arbiter: directed checks of the IRAM arbiter against a small behavioural SRAM.
module tb_iram_arbiter;
  logic clk = 1'b0;
  logic rst_b;
  int vecs = 0, errs = 0;
  int g0 = 0, r0 = 0, r1 = 0;
  int n0, n1, both, g0b, r0b, r1b;
  logic [1:0] prev;
  logic [1:0] seq [$];
  logic [127:0] mem [16] = '{default: '0};
  logic [127:0] mask;
  iram_arbiter_if #(.ADDR_W(20), .DATA_W(128)) bus ();
  iram_arbiter dut (.pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    mask = '0;
    for (int b = 0; b < 16; b++) mask[b*8 +: 8] = {8{~bus.ram_wen[b]}};
  end
  always @(posedge clk) begin
    if (!bus.ram_cen) begin
      mem[bus.ram_addr[3:0]] <= (mem[bus.ram_addr[3:0]] & ~mask) | (bus.ram_din & mask);
      bus.ram_dout <= mem[bus.ram_addr[3:0]];
    end
    if (bus.m0_gnt) g0 <= g0 + 1;
    if (bus.m0_rvalid) r0 <= r0 + 1;
    if (bus.m1_rvalid) r1 <= r1 + 1;
  end
  task automatic nx;
    @(posedge clk);
    #1;
  endtask
  task automatic ck(input string t, input logic [127:0] o, input logic [127:0] e);
    vecs++;
    if (o !== e) begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask
  initial begin
    rst_b = 1'b0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0; bus.m0_len = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0; bus.m1_len = '0;
    nx; nx;
    ck("rst_owner", bus.owner, 2'b00);
    ck("rst_gnt0", bus.m0_gnt, 1'b0);
    ck("rst_cen", bus.ram_cen, 1'b1);
    ck("rst_rvalid0", bus.m0_rvalid, 1'b0);
    rst_b = 1'b1;
    bus.m0_req = 1'b1; bus.m0_addr = 20'h10;
    #1 ck("single_idle_gnt", bus.m0_gnt, 1'b0);
    nx;
    ck("single_gnt", bus.m0_gnt, 1'b1);
    ck("single_addr", bus.ram_addr, 20'h10);
    ck("single_cen", bus.ram_cen, 1'b0);
    ck("single_wen", bus.ram_wen, 16'hFFFF);
    ck("single_owner", bus.owner, 2'b01);
    nx;
    bus.m0_req = 1'b0;
    #1 ck("single_rvalid", bus.m0_rvalid, 1'b1);
    ck("single_owner_back", bus.owner, 2'b00);
    ck("single_cen_off", bus.ram_cen, 1'b1);
    ck("single_rdata", bus.rdata, bus.ram_dout);
    nx;
    ck("single_rvalid_1cyc", bus.m0_rvalid, 1'b0);
    rst_b = 1'b0; nx; rst_b = 1'b1;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m0_len = 8'd3; bus.m1_len = 8'd3; bus.m1_addr = 20'h8;
    n0 = 0; n1 = 0; both = 0; prev = 2'b00; seq.delete(); r0b = r0; r1b = r1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.m0_gnt) n0++;
      if (bus.m1_gnt) n1++;
      if (bus.m0_gnt && bus.m1_gnt) both++;
      if (bus.owner != prev) begin seq.push_back(bus.owner); prev = bus.owner; end
      nx;
      if (n0 == 4) bus.m0_req = 1'b0;
      if (n1 == 4) bus.m1_req = 1'b0;
      bus.m0_addr = 20'(n0);
      bus.m1_addr = 20'(8 + n1);
    end
    ck("tie_m0_beats", n0, 4);
    ck("tie_m1_beats", n1, 4);
    ck("tie_overlap", both, 0);
    ck("tie_rvalid0", r0 - r0b, 4);
    ck("tie_rvalid1", r1 - r1b, 4);
    ck("tie_seq_len", seq.size(), 4);
    ck("tie_seq0", seq.size() > 0 ? seq[0] : 2'b11, 2'b01);
    ck("tie_seq1", seq.size() > 1 ? seq[1] : 2'b11, 2'b00);
    ck("tie_seq2", seq.size() > 2 ? seq[2] : 2'b11, 2'b10);
    ck("tie_seq3", seq.size() > 3 ? seq[3] : 2'b11, 2'b00);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_len = 8'd1; bus.m1_addr = 20'h4; bus.m1_wstrb = 16'h00FF;
    bus.m1_wdata = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98};
    #1 ck("wr_idle_gnt", bus.m1_gnt, 1'b0);
    nx;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_len = 8'd0; bus.m0_addr = 20'h4;
    #1 ck("wr_b1_gnt", bus.m1_gnt, 1'b1);
    ck("wr_b1_wen", bus.ram_wen, 16'hFF00);
    ck("wr_b1_din", bus.ram_din, bus.m1_wdata);
    ck("wr_b1_addr", bus.ram_addr, 20'h4);
    ck("wr_b1_m0_wait", bus.m0_gnt, 1'b0);
    nx;
    bus.m1_addr = 20'h5;
    #1 ck("wr_b2_gnt", bus.m1_gnt, 1'b1);
    ck("wr_b2_wen", bus.ram_wen, 16'hFF00);
    ck("wr_b2_addr", bus.ram_addr, 20'h5);
    ck("wr_b2_m0_wait", bus.m0_gnt, 1'b0);
    ck("wr_no_rvalid", bus.m1_rvalid, 1'b0);
    nx;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    #1 ck("wr_idle_owner", bus.owner, 2'b00);
    ck("wr_idle_m0", bus.m0_gnt, 1'b0);
    nx;
    ck("rd_gnt", bus.m0_gnt, 1'b1);
    ck("rd_owner", bus.owner, 2'b01);
    ck("rd_wen", bus.ram_wen, 16'hFFFF);
    nx;
    bus.m0_req = 1'b0;
    #1 ck("rd_rvalid", bus.m0_rvalid, 1'b1);
    ck("rd_data", bus.rdata, {64'h0, 64'h89AB_CDEF_FEDC_BA98});
    nx;
    bus.m0_req = 1'b1; bus.m0_len = 8'd3; bus.m0_addr = 20'h0; g0b = g0;
    nx;
    bus.m1_req = 1'b1; bus.m1_len = 8'd0; bus.m1_addr = 20'h2;
    #1 ck("bub_b1_gnt", bus.m0_gnt, 1'b1);
    nx;
    bus.m0_req = 1'b0;
    #1 ck("bub1_owner", bus.owner, 2'b01);
    ck("bub1_m0", bus.m0_gnt, 1'b0);
    ck("bub1_m1", bus.m1_gnt, 1'b0);
    nx;
    ck("bub2_owner", bus.owner, 2'b01);
    ck("bub2_m1", bus.m1_gnt, 1'b0);
    nx;
    bus.m0_req = 1'b1;
    for (int k = 1; k < 4; k++) begin
      bus.m0_addr = 20'(k);
      #1 ck("bub_m1_wait", bus.m1_gnt, 1'b0);
      nx;
    end
    bus.m0_req = 1'b0;
    #1 ck("bub_idle_owner", bus.owner, 2'b00);
    ck("bub_gnt_total", g0 - g0b, 4);
    nx;
    ck("bub_m1_gnt", bus.m1_gnt, 1'b1);
    ck("bub_m1_owner", bus.owner, 2'b10);
    nx;
    bus.m1_req = 1'b0;
    #1 ck("bub_m1_rvalid", bus.m1_rvalid, 1'b1);
    nx;
    bus.m1_req = 1'b1; bus.m1_len = 8'd7; bus.m1_addr = 20'h0;
    nx;
    ck("rst_b1_gnt", bus.m1_gnt, 1'b1);
    nx;
    bus.m1_addr = 20'h1;
    #1 ck("rst_b2_gnt", bus.m1_gnt, 1'b1);
    nx;
    ck("rst_b2_rvalid", bus.m1_rvalid, 1'b1);
    rst_b = 1'b0;
    #1 ck("rst_mid_gnt", bus.m1_gnt, 1'b0);
    ck("rst_mid_cen", bus.ram_cen, 1'b1);
    nx;
    ck("rst_after_owner", bus.owner, 2'b00);
    ck("rst_after_rvalid", bus.m1_rvalid, 1'b0);
    ck("rst_after_cen", bus.ram_cen, 1'b1);
    rst_b = 1'b1; bus.m1_req = 1'b0;
    nx;
    ck("rst_rel_rvalid", bus.m1_rvalid, 1'b0);
    ck("rst_rel_cen", bus.ram_cen, 1'b1);
    bus.m0_req = 1'b1; bus.m0_len = 8'd255; bus.m0_we = 1'b0; g0b = g0; r0b = r0; n0 = 0;
    for (int i = 0; i < 300 && n0 < 256; i++) begin
      bus.m0_addr = 20'(n0);
      #1 if (bus.m0_gnt) n0++;
      nx;
    end
    bus.m0_req = 1'b0;
    #1 ck("long_owner_idle", bus.owner, 2'b00);
    ck("long_beats_seen", n0, 256);
    nx; nx;
    ck("long_gnt", g0 - g0b, 256);
    ck("long_rvalid", r0 - r0b, 256);
    ck("long_owner_end", bus.owner, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
